// File: rtl/aes128_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryptor.
// The optional abort feature is selected in the top level by AES128_ABORT_EN.
package aes128_pkg;

  localparam int unsigned N  = 128;
  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} aes_state_e;

  localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = col;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [N-1:0] keyexp(input logic [N-1:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ subword({k[23:0], k[31:24]}) ^ {rcon, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_round_dp.sv
// Single AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes128_round_dp
  import aes128_pkg::*;
(
  input  logic [N-1:0] state_in,
  input  logic [N-1:0] round_key,
  input  logic         is_final,
  output logic [N-1:0] state_out
);

  logic [N-1:0] sr;
  logic [N-1:0] mc;

  always_comb begin
    sr = '0;
    mc = '0;
    // Byte (row r, col c) sits at index 4*c+r; ShiftRows takes it from column c+r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[N-1-8*(4*c+r) -: 8] = sbox(state_in[N-1-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[N-1-32*c -: 32] = mixcol(sr[N-1-32*c -: 32]);
    end
    state_out = (is_final ? sr : mc) ^ round_key;
  end

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller, one round per cycle with on-the-fly key expansion.
// Define AES128_ABORT_EN to add the abort input.
module aes128_enc_ctrl
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES128_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] plain_text,
  input  logic [N-1:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] cipher_text,
  output logic [3:0]   roundnum,
  output logic         busy
);

  aes_state_e   state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic [N-1:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   rcon_idx;
  logic [N-1:0] round_key;
  logic [N-1:0] round_out;
  logic         abort_req;
  logic         accept;

`ifdef AES128_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign rcon_idx  = (round_q == 4'd0 || round_q > 4'(NR)) ? 4'd0 : round_q - 4'd1;
  assign round_key = keyexp(key_q, RCON[rcon_idx]);

  aes128_round_dp u_round_dp (
    .state_in  (data_q),
    .round_key (round_key),
    .is_final  (state_q == StFinal),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRound;
      StRound: if (round_q == 4'(NR - 1)) state_d = StFinal;
      StFinal: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_req && state_q != StIdle) state_d = StIdle;
  end

  // Handshake outputs decode the state only; abort still masks acceptance in IDLE.
  always_comb begin
    in_ready  = (state_q == StIdle) && !abort_req;
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  always_comb begin
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = plain_text ^ cipher_key;
          key_d   = cipher_key;
          round_d = 4'd1;
        end
      end
      StRound: begin
        data_d  = round_out;
        key_d   = round_key;
        round_d = round_q + 4'd1;
      end
      StFinal: begin
        data_d = round_out;
        key_d  = round_key;
      end
      StDone:  if (out_ready) round_d = 4'd0;
      default: round_d = 4'd0;
    endcase
    if (abort_req && state_q != StIdle) begin
      data_d  = '0;
      key_d   = '0;
      round_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign cipher_text = data_q;
  assign roundnum    = round_q;

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Scoreboard bench for aes128_enc_ctrl: known-answer vectors plus random vectors against a
// table-driven AES model built from log/antilog tables.
module tb_aes128_enc_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plain_text = '0;
  logic [127:0] cipher_key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] cipher_text;
  logic [3:0]   roundnum;
`ifdef AES128_ABORT_EN
  logic         abort = 1'b0;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb  [256];
  logic [7:0]   alg [256];
  int           lg  [256];

  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes128_enc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES128_ABORT_EN
    .abort       (abort),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plain_text  (plain_text),
    .cipher_key  (cipher_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cipher_text (cipher_text),
    .roundnum    (roundnum),
    .busy        (busy)
  );

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alg[(lg[a] + lg[b]) % 255];
  endfunction

  // Antilog table over generator 3, then inverse + bitwise affine transform.
  task automatic build_tables();
    logic [7:0] p, b, s, c;
    p = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      alg[i] = p;
      lg[p]  = i;
      p      = p ^ mul2(p);
    end
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : alg[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++) begin
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      end
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   w  [44][4];
    logic [7:0]   s  [4][4];
    logic [7:0]   t  [4][4];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tw[j] = sb[w[i-1][(j+1)%4]];
        tw[0] = tw[0] ^ rc;
        rc    = mul2(rc);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tw[j];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10) s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else          s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rnd+c][r];
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp, output longint t_acc);
    plain_text = pt;
    cipher_key = key;
    in_valid   = 1'b1;
    t_acc      = -1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        @(posedge clk);
        t_acc = longint'($time);
        exp_q.push_back(exp);
        #1;
        in_valid   = 1'b0;
        plain_text = rand128();
        cipher_key = rand128();
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout: in_ready low for 40 cycles, required high");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", 128'(exp_q.size()), 128'd0);
    tick();
  endtask

  // Monitor: every output handshake pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", cipher_text);
      end else begin
        check("cipher_text", cipher_text, exp_q.pop_front());
      end
    end
  end

  initial begin
    longint     t0, t1, t2;
    int         lat;
    logic [127:0] pt, key;

    build_tables();

    #2;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_roundnum", 128'(roundnum), 128'd0);
    check("rst_cipher_text", cipher_text, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // App. B with latency measurement.
    out_ready = 1'b0;
    send(PtB, KeyB, CtB, t0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("latency_B", 128'(lat), 128'd10);
    out_ready = 1'b1;
    tick();
    tick();
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_out_valid", 128'(out_valid), 128'd0);

    // App. C.1 with roundnum stepping.
    send(PtC, KeyC, CtC, t0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("roundnum_%0d", i + 1), 128'(roundnum), 128'(i + 1));
      check("busy_running", 128'(busy), 128'd1);
      tick();
    end
    tick();
    tick();

    // All-zero vector under 20 cycles of backpressure, with a competing in_valid.
    out_ready = 1'b0;
    send('0, '0, CtZ, t0);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      in_valid   = 1'b1;
      plain_text = rand128();
      cipher_key = rand128();
      check("stall_cipher_text", cipher_text, CtZ);
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Back-to-back random vectors, accepts 12 cycles apart.
    out_ready = 1'b1;
    pt = rand128(); key = rand128();
    send(pt, key, aes_ref(pt, key), t0);
    pt = rand128(); key = rand128();
    send(pt, key, aes_ref(pt, key), t1);
    pt = rand128(); key = rand128();
    send(pt, key, aes_ref(pt, key), t2);
    check("b2b_gap_1", 128'((t1 - t0) / 10), 128'd12);
    check("b2b_gap_2", 128'((t2 - t1) / 10), 128'd12);
    drain();

    // Asynchronous reset at round 5, then a clean App. B run.
    send(PtB, KeyB, CtB, t0);
    repeat (4) tick();
    check("roundnum_before_reset", 128'(roundnum), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_roundnum", 128'(roundnum), 128'd0);
    check("mid_rst_cipher_text", cipher_text, 128'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(PtB, KeyB, CtB, t0);
    drain();

`ifdef AES128_ABORT_EN
    send(PtC, KeyC, CtC, t0);
    repeat (6) tick();
    check("roundnum_before_abort", 128'(roundnum), 128'd7);
    abort = 1'b1;
    tick();
    void'(exp_q.pop_back());
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_roundnum", 128'(roundnum), 128'd0);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("abort_no_accept", 128'(busy), 128'd0);
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    tick();
    check("abort_cipher_cleared", cipher_text, 128'd0);
`endif

    // Random vectors with random backpressure.
    for (int v = 0; v < 8; v++) begin
      pt  = rand128();
      key = rand128();
      out_ready = 1'b1;
      send(pt, key, aes_ref(pt, key), t0);
      for (int j = 0; j < 200; j++) begin
        if (exp_q.size() == 0) break;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
